// File: rtl/wb_hazard_unit.sv
// EX/WB pipeline register with load-data extraction and load-use stall detection.
// Define LOAD_USE_STALL_EN to enable the hazard FSM, stall/kill_ex and stall_cnt.
module wb_hazard_unit #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_we,
    input  logic              ex_is_load,
    input  logic [2:0]        ex_funct3,
    input  logic [DWIDTH-1:0] ex_result,
    input  logic [DWIDTH-1:0] mem_rdata,
    input  logic              flush,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    output logic [4:0]        wb_addr,
    output logic [DWIDTH-1:0] wb_data,
    output logic              is_wb,
    output logic              stall,
    output logic              kill_ex,
    output logic [15:0]       stall_cnt,
    output logic              fsm_state
);

    logic              is_load_q;
    logic [2:0]        funct3_q;
    logic [1:0]        addr_lo_q;
    logic [DWIDTH-1:0] result_q;

    // A bubble in EX must never produce a write-back, so valid gates both address and enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_wb     <= 1'b0;
            wb_addr   <= '0;
            is_load_q <= 1'b0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
            result_q  <= '0;
        end else begin
            is_wb     <= ex_valid & ex_reg_we & (ex_rd != 5'd0);
            wb_addr   <= ex_valid ? ex_rd : 5'd0;
            is_load_q <= ex_is_load;
            funct3_q  <= ex_funct3;
            addr_lo_q <= ex_result[1:0];
            result_q  <= ex_result;
        end
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = mem_rdata[8*addr_lo_q +: 8];
        ld_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        wb_data = result_q;
        if (is_load_q) begin
            case (funct3_q)
                3'b000:  wb_data = {{(DWIDTH-8){ld_byte[7]}}, ld_byte};
                3'b001:  wb_data = {{(DWIDTH-16){ld_half[15]}}, ld_half};
                3'b100:  wb_data = {{(DWIDTH-8){1'b0}}, ld_byte};
                3'b101:  wb_data = {{(DWIDTH-16){1'b0}}, ld_half};
                default: wb_data = mem_rdata;
            endcase
        end
    end

`ifdef LOAD_USE_STALL_EN
    typedef enum logic {
        RUN     = 1'b0,
        STALLED = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   hazard;

    // Flush kills the ID instruction, so a dependency on it is moot.
    assign hazard = ex_valid & ex_is_load & ex_reg_we & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd))) &
                    ~flush;

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        kill_ex = 1'b0;
        case (state_q)
            RUN: begin
                if (hazard) begin
                    stall   = 1'b1;
                    kill_ex = 1'b1;
                    state_d = STALLED;
                end
            end
            STALLED: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            stall_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    assign fsm_state = (state_q == STALLED);
`else
    logic unused_id;
    assign unused_id = ^{id_rs1, id_rs2, id_use_rs1, id_use_rs2, flush};

    assign stall     = 1'b0;
    assign kill_ex   = 1'b0;
    assign stall_cnt = '0;
    assign fsm_state = 1'b0;
`endif

endmodule

// File: doc/wb_hazard_unit.md
# wb_hazard_unit

Producer side of EX-stage operand forwarding: registers the instruction retiring from EX and drives the write-back address, data and valid consumed by the forwarding unit and the register file. Extracts and extends load data from the synchronous data memory, and detects load-use hazards that forwarding cannot cover, issuing a one-cycle decode stall plus an EX bubble. Sits at the EX/WB boundary of the 3-stage core.

## Interface
- DWIDTH, 32, datapath width; only 32 is supported.
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX holds a real (non-bubble) instruction this cycle.
- ex_rd  in  5  EX destination register.
- ex_reg_we  in  1  EX instruction writes rd.
- ex_is_load  in  1  EX instruction is a load.
- ex_funct3  in  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- ex_result  in  DWIDTH  ALU result; for loads, the byte address.
- mem_rdata  in  DWIDTH  data-memory read word, valid the cycle after the address.
- flush  in  1  branch/jump redirect; kills the ID instruction.
- id_rs1, id_rs2  in  5  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2.
- wb_addr  out  5  write-back register address (reset 0).
- wb_data  out  DWIDTH  write-back data (reset 0).
- is_wb  out  1  write-back valid (reset 0).
- stall  out  1  hold PC and ID this cycle (reset 0).
- kill_ex  out  1  insert a bubble into EX next cycle (reset 0).
- stall_cnt  out  16  count of issued stalls (reset 0).

## Operation
- WB pipeline register:
  - Each cycle, captures ex_valid & ex_reg_we & (ex_rd != 0) as is_wb, ex_rd as wb_addr, ex_is_load, ex_funct3, ex_result[1:0], and ex_result.
  - When the captured ex_valid is 0, wb_addr is forced to 0 and is_wb to 0.
- wb_data:
  - Non-load: the registered ex_result.
  - Load: combinational extraction from mem_rdata using the registered addr_lo.
    - LB/LBU: byte at addr_lo, sign- or zero-extended.
    - LH/LHU: halfword at addr_lo[1], sign- or zero-extended; addr_lo[0] is ignored.
    - LW: the whole word; addr_lo is ignored.
    - Undefined funct3: the whole word.
- Hazard detection (combinational, RUN state only):
  - hazard = ex_valid & ex_is_load & ex_reg_we & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)) & !flush.
- FSM, two states:
  - RUN: hazard → stall=1, kill_ex=1, go to STALLED. No hazard → stay in RUN.
  - STALLED: stall=0, kill_ex=0, hazard masked; always return to RUN. The load is now in WB and is forwarded normally.
- stall_cnt increments on each cycle where stall=1 and saturates at 16'hFFFF.
- flush has priority over hazard: no stall or kill when flush=1.
- Reset mid-operation returns the FSM to RUN and all outputs to 0, including a pending load's write-back. stall_cnt is cleared.

## Timing
- EX instruction at cycle N appears on wb_addr/is_wb/wb_data in cycle N+1. For loads, wb_data is valid in N+1 through mem_rdata.
- stall and kill_ex are combinational in cycle N, where N is the cycle the load occupies EX. They are high for exactly one cycle per load-use pair.
- A back-to-back load-use chain (load, dependent load, dependent use) costs one stall per pair. The second load re-enters EX in cycle N+2 and can trigger again, because the FSM is back in RUN.
- No combinational path from mem_rdata to stall.

## Configuration
- LOAD_USE_STALL_EN defined: hazard detection, FSM and stall_cnt are active as above.
- LOAD_USE_STALL_EN undefined:
  - stall, kill_ex and stall_cnt are tied to 0 and the FSM is removed.
  - Software must schedule a non-dependent instruction after every load.
  - WB register and load extraction are unchanged.

## Test plan
- ALU write: ex_rd=5, ex_reg_we=1, ex_result=32'h1234 at N → N+1: wb_addr=5, is_wb=1, wb_data=32'h1234.
- Loads with mem_rdata=32'h80FF7F01:
  - LB, addr_lo=3 → wb_data=32'hFFFFFF80.
  - LBU, addr_lo=2 → wb_data=32'h000000FF.
  - LH, addr_lo=2 → wb_data=32'hFFFF80FF.
  - LHU, addr_lo=0 → wb_data=32'h00007F01.
- rd=0 suppression: ex_rd=0, ex_reg_we=1 → is_wb=0 in N+1.
- Load-use: LW x7 in EX, ID reads rs2=x7 with id_use_rs2=1 → stall=1, kill_ex=1 in N only. Stall low in N+1. stall_cnt=1.
- Same load-use case with flush=1 in N → stall=0, kill_ex=0, stall_cnt unchanged.
- Reset mid-stall: rst=1 in the cycle after the stall → all outputs 0 and FSM in RUN next cycle. A hazard two cycles later stalls again.
